// File: rtl/lot_lane_tracker_if.sv
// lot_lane_tracker_if: per-lane beam sensors in, lane events and shared occupancy state out.
interface lot_lane_tracker_if #(
  parameter int NUM_LANES = 2,
  parameter int CNT_W = 7
);
  logic [NUM_LANES-1:0] sens_out, sens_in, lane_enter, lane_exit, lane_abort;
  logic clr_count, full, empty, refused;
  logic [CNT_W-1:0] count;
  modport master (
    output sens_out, sens_in, clr_count,
    input lane_enter, lane_exit, lane_abort, count, full, empty, refused
  );
  modport slave (
    input sens_out, sens_in, clr_count,
    output lane_enter, lane_exit, lane_abort, count, full, empty, refused
  );
endinterface

// File: rtl/lot_lane_tracker.sv
// lot_lane_tracker: per-gate entry/exit FSMs feeding a shared saturating occupancy counter.
// Define DEBOUNCE_EN to add a 2-flop synchronizer and DB_CYC-sample stability filter per sensor bit.
module lot_lane_tracker #(
  parameter int NUM_LANES = 2,
  parameter int CAPACITY = 99,
  parameter int CNT_W = 7,
  parameter int TIMEOUT_CYC = 1000,
  parameter int DB_CYC = 4
) (
  input logic clk,
  input logic rst_n,
  lot_lane_tracker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARM, BOTH, CLEAR} state_t;
  localparam int TW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int SW = CNT_W + 4;
  if (NUM_LANES < 1 || NUM_LANES > 8 || CAPACITY < 1 || CAPACITY >= 2 ** CNT_W || DB_CYC < 1) begin : g_bad_param
    $error("lot_lane_tracker: illegal parameter set");
  end
  logic [2*NUM_LANES-1:0] w_raw, w_flt;
  logic [NUM_LANES-1:0] w_ent, w_ext, w_abt;
  assign w_raw = {bus.sens_in, bus.sens_out};
`ifdef DEBOUNCE_EN
  localparam int DW = $clog2(DB_CYC + 1);
  for (genvar b = 0; b < 2 * NUM_LANES; b++) begin : g_db
    logic r_s1, r_s2, r_f;
    logic [DW-1:0] r_n;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {r_s1, r_s2, r_f, r_n} <= '0;
      else begin
        r_s1 <= w_raw[b];
        r_s2 <= r_s1;
        r_n <= (r_s2 == r_f || r_n == DW'(DB_CYC - 1)) ? '0 : r_n + 1'b1;
        if (r_s2 != r_f && r_n == DW'(DB_CYC - 1)) r_f <= r_s2;
      end
    assign w_flt[b] = r_f;
  end
`else
  assign w_flt = w_raw;
`endif
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    state_t r_st, w_nx;
    logic r_dir, r_lock, r_en, r_ex, r_ab, w_so, w_si, w_lead, w_trail, w_bad, w_to;
    logic [TW-1:0] r_tm;
    assign w_so = w_flt[l];
    assign w_si = w_flt[NUM_LANES+l];
    // r_dir = 1 means an exit, so the inner beam leads
    assign w_lead = r_dir ? w_si : w_so;
    assign w_trail = r_dir ? w_so : w_si;
    always_comb begin
      w_nx = (w_lead && w_trail) ? BOTH : w_lead ? (r_st == CLEAR ? IDLE : ARM)
           : w_trail ? (r_st == ARM ? IDLE : CLEAR) : IDLE;
      w_bad = (w_lead ^ w_trail) ? (w_lead ? r_st == CLEAR : r_st == ARM) : (!w_lead && r_st == BOTH);
      w_to = TIMEOUT_CYC != 0 && w_nx == r_st && r_tm == TW'(TIMEOUT_CYC - 1);
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_st <= IDLE;
        {r_dir, r_lock, r_en, r_ex, r_ab} <= '0;
        r_tm <= '0;
      end else begin
        r_en <= 1'b0;
        r_ex <= 1'b0;
        r_ab <= 1'b0;
        if (r_st == IDLE) begin
          r_tm <= '0;
          if (r_lock) r_lock <= w_so | w_si;
          else if (w_so ^ w_si) begin
            r_st <= ARM;
            r_dir <= w_si;
          end
        end else if (w_bad || w_to) begin
          r_st <= IDLE;
          r_ab <= 1'b1;
          r_lock <= 1'b1;
          r_tm <= '0;
        end else begin
          r_st <= w_nx;
          r_tm <= (w_nx == r_st) ? r_tm + 1'b1 : '0;
          r_en <= r_st == CLEAR && w_nx == IDLE && !r_dir;
          r_ex <= r_st == CLEAR && w_nx == IDLE && r_dir;
        end
      end
    assign w_ent[l] = r_en;
    assign w_ext[l] = r_ex;
    assign w_abt[l] = r_ab;
  end
  logic [CNT_W-1:0] r_cnt;
  logic r_ref;
  logic signed [SW-1:0] w_sum, w_clp;
  // opposite events cancel before the clamp is applied
  always_comb begin
    w_sum = SW'(r_cnt);
    for (int k = 0; k < NUM_LANES; k++) w_sum = w_sum + SW'(w_ent[k]) - SW'(w_ext[k]);
    w_clp = w_sum < 0 ? '0 : w_sum > SW'(CAPACITY) ? SW'(CAPACITY) : w_sum;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_ref <= 1'b0;
    end else begin
      r_cnt <= bus.clr_count ? '0 : CNT_W'(w_clp);
      r_ref <= !bus.clr_count && w_clp != w_sum;
    end
  assign bus.count = r_cnt;
  assign bus.full = r_cnt == CNT_W'(CAPACITY);
  assign bus.empty = r_cnt == '0;
  assign bus.refused = r_ref;
  assign bus.lane_enter = w_ent;
  assign bus.lane_exit = w_ext;
  assign bus.lane_abort = w_abt;
endmodule
